// File: rtl/counter_updown_mod_if.sv
// Control/status bundle for counter_updown_mod: count controls in, count and flags out.
// master drives the controls; slave is the counter itself.
interface counter_updown_mod_if #(
    parameter int dw = 8
);
    logic          ena;
    logic          up;
    logic          sat;
    logic          load;
    logic [dw-1:0] load_val;
    logic [dw-1:0] result;
    logic          tc;
    logic          wrap;

    modport master (
        output ena, up, sat, load, load_val,
        input  result, tc, wrap
    );

    modport slave (
        input  ena, up, sat, load, load_val,
        output result, tc, wrap
    );
endinterface

// File: rtl/counter_updown_mod.sv
// Up/down modulo counter over 0..MAXV with load, wrap/saturate bounds, tc level and wrap pulse.
// Optional prescaler enabled by defining COUNTER_PRESCALE_EN.
module counter_updown_mod #(
    parameter int dw    = 8,
    parameter int WIDTH = 7,
    parameter int MAXV  = 2**dw - 1,
    parameter int PRESC = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    counter_updown_mod_if.slave  bus
);
    localparam logic [dw-1:0] MAXV_L  = dw'(MAXV);
    localparam logic [dw-1:0] RESET_L = dw'(WIDTH);

    // Parameter sanity: refuse to elaborate an inconsistent configuration.
    generate
        if (WIDTH > MAXV) begin : g_bad_reset
            $error("counter_updown_mod: WIDTH (reset value) exceeds MAXV");
        end
        if (longint'(MAXV) >= (64'd1 << dw)) begin : g_bad_maxv
            $error("counter_updown_mod: MAXV does not fit in dw bits");
        end
        if (PRESC < 1) begin : g_bad_presc
            $error("counter_updown_mod: PRESC must be at least 1");
        end
    endgenerate

    logic [dw-1:0] result_reg, result_next;
    logic          wrap_reg, wrap_next;
    logic          step;

`ifdef COUNTER_PRESCALE_EN
    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0] PLAST = PW'(PRESC - 1);

    logic [PW-1:0] pcnt_reg, pcnt_next;

    // A step is granted only on the last enabled cycle of each prescale period.
    assign step = bus.ena && (pcnt_reg == PLAST);

    always_comb begin
        pcnt_next = pcnt_reg;
        if (bus.load) begin
            pcnt_next = '0;
        end else if (bus.ena) begin
            pcnt_next = (pcnt_reg == PLAST) ? '0 : pcnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt_reg <= '0;
        end else begin
            pcnt_reg <= pcnt_next;
        end
    end
`else
    assign step = bus.ena;
`endif

    always_comb begin
        result_next = result_reg;
        wrap_next   = 1'b0;
        if (bus.load) begin
            result_next = (bus.load_val > MAXV_L) ? MAXV_L : bus.load_val;
        end else if (step) begin
            if (bus.up) begin
                // Compare against MAXV rather than relying on dw-bit rollover.
                if (result_reg < MAXV_L) begin
                    result_next = result_reg + 1'b1;
                end else if (!bus.sat) begin
                    result_next = '0;
                    wrap_next   = 1'b1;
                end
            end else begin
                if (result_reg != '0) begin
                    result_next = result_reg - 1'b1;
                end else if (!bus.sat) begin
                    result_next = MAXV_L;
                    wrap_next   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_reg <= RESET_L;
            wrap_reg   <= 1'b0;
        end else begin
            result_reg <= result_next;
            wrap_reg   <= wrap_next;
        end
    end

    assign bus.result = result_reg;
    assign bus.wrap   = wrap_reg;
    assign bus.tc     = bus.up ? (result_reg == MAXV_L) : (result_reg == '0);

endmodule
